// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver: blank pattern,
// hex-to-segment table and the all-anodes-off mask.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n sits at bits [8n+7:8n], dp bit held high (off).
  localparam logic [127:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[{nibble, 3'b000} +: 8];
  endfunction

  // Low n bits set: every anode of an n-digit display driven inactive.
  function automatic logic [7:0] anode_off(input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg    = hex_seg(nibble);
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous data commit,
// leading-zero suppression, PWM brightness and an anti-ghost guard at each slot start.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lzs_en,
  input  logic [3:0]              brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0]      DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_GUARD   = DIV_W'(GUARD);
  localparam logic [7:0]            AN_OFF_FULL = anode_off(int'(NUM_DIGITS));
  localparam logic [NUM_DIGITS-1:0] AN_OFF      = AN_OFF_FULL[NUM_DIGITS-1:0];

  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;
  logic [3:0]              pwm_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q, disp_data_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, disp_dp_q;
  logic [NUM_DIGITS-1:0]   sh_en_q, disp_en_q;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    tick_q;

  logic                    slot_end, frame_end;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;
  logic [3:0]              sel_nibble;
  logic                    sel_dp, sel_blank;
  logic [7:0]              dec_seg;
  logic [7:0]              seg_d;
  logic [NUM_DIGITS-1:0]   an_d;

  assign slot_end  = (div_q == DIV_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Walk from the most significant digit down; disabled digits keep the zero run
  // alive, while a nonzero nibble or a lit dp ends it.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run &
                 (~disp_en_q[i] | ((disp_data_q[4*i +: 4] == 4'h0) & ~disp_dp_q[i]));
      blank_mask[i] = ~disp_en_q[i] | (lzs_en & zero_run & (i != 0));
    end
  end

  always_comb begin
    sel_nibble = disp_data_q[4*int'(idx_q) +: 4];
    sel_dp     = disp_dp_q[idx_q];
    sel_blank  = blank_mask[idx_q];
  end

  seg7_hex_decode u_decode (
    .nibble (sel_nibble),
    .dp     (sel_dp),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d = AN_OFF;
    if ((div_q >= DIV_GUARD) && (pwm_q <= brightness)) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = ((an_d == AN_OFF) || sel_blank) ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      disp_en_q   <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= AN_OFF;
      tick_q      <= 1'b0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      if (slot_end) begin
        div_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (load) begin
        sh_data_q <= data_in;
        sh_dp_q   <= dp_in;
        sh_en_q   <= digit_en;
      end
      // Commit reads the pre-edge shadow, so a coincident load lands one frame later.
      if (frame_end) begin
        disp_data_q <= sh_data_q;
        disp_dp_q   <= sh_dp_q;
        disp_en_q   <= sh_en_q;
      end
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= frame_end;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
